// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code constants and the buffered result payload.
// The overflow field exists only when ALU_OVF_EN is defined.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             zero;
        logic             illegal;
`ifdef ALU_OVF_EN
        logic             overflow;
`endif
    } alu_payload_t;

    function automatic logic alu_code_legal(input logic [2:0] code);
        logic legal;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
            default:                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic two-entry skid buffer: main register M drives the outputs, skid register S
// absorbs one extra beat so in_ready is a pure register with no path from out_ready.
module alu_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         m_valid_r, s_valid_r, in_ready_r;
    logic [W-1:0] m_data_r, s_data_r;
    logic         m_valid_s, s_valid_s;
    logic [W-1:0] m_data_s, s_data_s;
    logic         accept_s, drain_s;

    // Next-state selection for the M/S pair; S is only ever filled while M is stalled.
    always_comb begin
        accept_s  = in_valid && in_ready_r;
        drain_s   = m_valid_r && out_ready;
        m_valid_s = m_valid_r;
        s_valid_s = s_valid_r;
        m_data_s  = m_data_r;
        s_data_s  = s_data_r;
        if (s_valid_r) begin
            if (drain_s) begin
                m_data_s  = s_data_r;
                s_valid_s = 1'b0;
            end else begin
                s_valid_s = 1'b1;
            end
        end else if (accept_s) begin
            if (!m_valid_r || drain_s) begin
                m_data_s  = in_data;
                m_valid_s = 1'b1;
            end else begin
                s_data_s  = in_data;
                s_valid_s = 1'b1;
            end
        end else if (drain_s) begin
            m_valid_s = 1'b0;
        end else begin
            m_valid_s = m_valid_r;
        end
    end

    // Storage registers; in_ready tracks the next occupancy of S.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r  <= 1'b0;
            s_valid_r  <= 1'b0;
            in_ready_r <= 1'b1;
            m_data_r   <= '0;
            s_data_r   <= '0;
        end else begin
            m_valid_r  <= m_valid_s;
            s_valid_r  <= s_valid_s;
            in_ready_r <= !s_valid_s;
            m_data_r   <= m_data_s;
            s_data_r   <= s_data_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = m_valid_r;
    assign out_data  = m_data_r;

endmodule

// File: rtl/alu_exec.sv
// Registered, valid/ready handshaked 32-bit ALU execution stage with a two-entry
// output skid buffer. Define ALU_OVF_EN to add the signed-overflow output.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);

    logic [WIDTH-1:0] sum_s, diff_s, res_s;
    logic             sub_ovf_s, ill_s;
    alu_payload_t     cap_s, out_s;
`ifdef ALU_OVF_EN
    logic             add_ovf_s, ovf_s;
`endif

    // Operation select; SLT corrects the difference sign by overflow for a true signed compare.
    always_comb begin
        sum_s     = src_a + src_b;
        diff_s    = src_a - src_b;
        sub_ovf_s = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff_s[WIDTH-1] != src_a[WIDTH-1]);
`ifdef ALU_OVF_EN
        add_ovf_s = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_s[WIDTH-1] != src_a[WIDTH-1]);
        ovf_s     = 1'b0;
`endif
        res_s     = '0;
        ill_s     = !alu_code_legal(alu_control);
        case (alu_control)
            ALU_AND: res_s = src_a & src_b;
            ALU_OR:  res_s = src_a | src_b;
            ALU_ADD: begin
                res_s = sum_s;
`ifdef ALU_OVF_EN
                ovf_s = add_ovf_s;
`endif
            end
            ALU_SUB: begin
                res_s = diff_s;
`ifdef ALU_OVF_EN
                ovf_s = sub_ovf_s;
`endif
            end
            ALU_SLT: res_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovf_s};
            default: res_s = '0;
        endcase
    end

    // Flags are frozen with the result at capture so they travel through the buffer.
    always_comb begin
        cap_s.result  = res_s;
        cap_s.zero    = (res_s == '0);
        cap_s.illegal = ill_s;
`ifdef ALU_OVF_EN
        cap_s.overflow = ovf_s;
`endif
    end

    alu_skid_buf #(
        .W ($bits(alu_payload_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (cap_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_s)
    );

    assign result  = out_s.result;
    assign zero    = out_s.zero;
    assign illegal = out_s.illegal;
`ifdef ALU_OVF_EN
    assign overflow = out_s.overflow;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table with out_ready high, then backpressure
// ordering and mid-stall reset sequences. Overflow checks are built with ALU_OVF_EN.
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
`ifdef ALU_OVF_EN
    logic        overflow;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ill;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[16];

    alu_exec dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
`ifdef ALU_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op with out_ready high; called at a negedge, returns at the next negedge.
    task automatic run_vec(input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        alu_control = vecs[idx].ctrl;
        src_a       = vecs[idx].a;
        src_b       = vecs[idx].b;
        in_valid    = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, result, vecs[idx].exp_res);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, vecs[idx].exp_zero});
        chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, vecs[idx].exp_ill});
`ifdef ALU_OVF_EN
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, vecs[idx].exp_ovf});
`endif
    endtask

    logic [31:0] got[$];
    logic        acc;

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = 3'b000;
        src_a       = 32'd0;
        src_b       = 32'd0;

        vecs[0]  = '{3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b110, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b000, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b001, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b111, 32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b011, 32'd9,          32'd3,          32'd0,          1'b1, 1'b1, 1'b0};
        vecs[8]  = '{3'b010, 32'd2,          32'd3,          32'd5,          1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 32'd1,          32'd1,          32'd0,          1'b1, 1'b1, 1'b0};
        vecs[10] = '{3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'b010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'b110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
        vecs[14] = '{3'b010, 32'd1,          32'd1,          32'd2,          1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b111, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b1, 1'b0, 1'b0};

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, zero, illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_vec(i);
        end
        @(negedge clk);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: two accepts absorbed, third stalls, then drain in order.
        out_ready   = 1'b0;
        alu_control = 3'b010;
        src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp1_result", result, 32'd2);
        src_a = 32'd2; src_b = 32'd2;
        @(posedge clk); @(negedge clk);
        chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp2_result", result, 32'd2);
        src_a = 32'd3; src_b = 32'd3;
        @(posedge clk); @(negedge clk);
        chk("bp3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp3_result_held", result, 32'd2);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            if (out_valid) got.push_back(result);
            acc = in_valid && in_ready;
            @(posedge clk); @(negedge clk);
            if (acc) in_valid = 1'b0;
            if (got.size() >= 3) break;
        end
        in_valid = 1'b0;
        chk("bp_count", got.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk($sformatf("bp_order%0d", k), got[k], 32'(2 * (k + 1)));
        end
        @(negedge clk);
        chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_done_ready", {31'd0, in_ready}, 32'd1);

        // Fill M and S, then reset asynchronously mid-stall.
        out_ready   = 1'b0;
        alu_control = 3'b010;
        src_a = 32'd9; src_b = 32'd1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        src_a = 32'h7FFF_FFFF; src_b = 32'd1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_result", result, 32'd10);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_result", result, 32'd0);
        chk("arst_flags", {30'd0, zero, illegal}, 32'd0);
`ifdef ALU_OVF_EN
        chk("arst_overflow", {31'd0, overflow}, 32'd0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        alu_control = 3'b010;
        src_a = 32'd20; src_b = 32'd22; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_result", result, 32'd42);
        @(posedge clk); @(negedge clk);
        chk("post_rst_drained", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Handshaked, registered execution unit that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the selected 32-bit operation. It sits between decode and writeback in the pipelined variant of the MIPS datapath. It accepts one operation per cycle over a valid/ready interface and returns the result with zero/illegal flags one cycle later. A two-entry output skid buffer lets writeback stall without combinational ready paths back into decode.

## Interface
- `WIDTH`, 32: operand/result width in bits.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: unit can accept a request. Driven directly from a register.
- `alu_control` input, 3 bits: operation code.
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `src_a` input, WIDTH bits: operand A.
- `src_b` input, WIDTH bits: operand B.
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: consumer accepts the result.
- `result` output, WIDTH bits: operation result.
- `zero` output, 1 bit: `result == 0`.
- `illegal` output, 1 bit: the request carried an undefined code (011, 100, 101).
- `overflow` output, 1 bit: signed overflow on ADD/SUB. Present only with `ALU_OVF_EN`.

## Operation
**Transfers**
- Input transfer occurs when `in_valid && in_ready` at a rising edge.
- Output transfer occurs when `out_valid && out_ready` at a rising edge.

**Result computation**
- AND and OR are bitwise.
- ADD and SUB use modulo-2^WIDTH arithmetic; the carry-out is discarded.
- SLT is signed: result = {WIDTH-1 zeros, (A − B) sign corrected by overflow}, i.e. a true signed compare.
  - Example: 0x80000000 < 0x00000001 gives 1.
- Undefined codes give result 0, `illegal` = 1, `zero` = 1.
- `zero` and `illegal` are computed at capture and travel with the result.

**Storage**
- Storage is a main register M plus a skid register S; each holds {result, zero, illegal, overflow} and a valid bit.
- The outputs always present M.
- `in_ready` = !S.valid, registered.

**Per-edge cases**
- Accept with M empty, or M drained in the same cycle: the new result loads M.
- Accept while M is full and not draining: the new result loads S, and `in_ready` falls next cycle.
- Drain with S full: S moves to M and S empties. No accept is possible in this case because `in_ready` is 0.
- Drain with S empty and no accept: M empties and `out_valid` falls.
- Simultaneous accept and drain with M full and S empty: M loads the new result; `out_valid` stays 1.

**Ordering and stability**
- Results emerge in request order.
- No request is dropped or duplicated.
- `result`, `zero`, `illegal` and `overflow` are held stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: a request accepted at edge N is visible on the outputs after edge N, provided M was free.
- Throughput is 1 operation per cycle when `out_ready` is held high.
- With `out_ready` low, two requests are absorbed; `in_ready` deasserts in the cycle after the second accept.
- After `out_ready` returns high, `in_ready` reasserts one cycle after S drains.
- Reset (`rst_n` low, at any time, including mid-stall) immediately forces:
  - M.valid = 0 and S.valid = 0, so `out_valid` = 0.
  - `in_ready` = 1.
  - `result` = 0, `zero` = 0, `illegal` = 0, `overflow` = 0.
- Any in-flight results are discarded by reset.
- Outputs are X-free from reset onward.

## Configuration
- Macro `ALU_OVF_EN`.
- Defined:
  - The `overflow` port exists.
  - For ADD, overflow = (A[MSB] == B[MSB]) && (R[MSB] != A[MSB]).
  - For SUB, overflow = (A[MSB] != B[MSB]) && (R[MSB] != A[MSB]).
  - For all other codes, including illegal, overflow = 0.
  - The flag is buffered in M and S with the result.
- Undefined:
  - The port is absent and no overflow storage is built.
  - All other behaviour is identical.

## Structure
- Shared package `alu_pkg` holds:
  - The 3-bit code constants (AND, OR, ADD, SUB, SLT).
  - A typedef for the buffered payload {result, zero, illegal, overflow}.
- The ALU control decoder imports the same constants.
- One natural sub-module is `alu_skid_buf`, a generic two-entry skid buffer parameterised on payload width.
- The compute logic stays in `alu_exec`.

## Test plan
- ADD 5 + 7 with `out_ready` = 1 → one cycle later `result` = 12, `zero` = 0, `illegal` = 0.
  - Then SUB 5 − 5 → `result` = 0, `zero` = 1.
- SLT with 0xFFFFFFFF, 0x00000001 → 1. SLT with 0x00000001, 0xFFFFFFFF → 0.
  - AND 0xF0F0, 0xFF00 → 0xF000. OR 0xF0F0, 0x0F0F → 0xFFFF.
- Backpressure:
  - Hold `out_ready` = 0 and send ADD 1+1, ADD 2+2 and ADD 3+3 back-to-back. `in_ready` falls after the second accept and the third stalls.
  - Release `out_ready` → results 2, 4, 6 appear in order, none lost or duplicated.
- Code 011 with A = 9, B = 3 → `result` = 0, `illegal` = 1, `zero` = 1. The next legal op clears `illegal`.
- With `ALU_OVF_EN`:
  - ADD 0x7FFFFFFF + 1 → `result` = 0x80000000, `overflow` = 1.
  - SUB 0x80000000 − 1 → `overflow` = 1.
  - ADD 1 + 1 → `overflow` = 0.
- Fill both entries, then pulse `rst_n` low mid-stall → asynchronously `out_valid` = 0, `in_ready` = 1 and all outputs 0. The first op accepted after release returns the correct result.
